// File: rtl/ins_loader.sv
// ins_loader: streams a length-prefixed big-endian program into instruction memory while holding the CPU in reset.
module ins_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic [31:0]       W_Ins,
  output logic              WE,
  output logic [ADDR_W-1:0] WAddr,
  output logic              CpuRST,
  output logic              Done,
  output logic              Err
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
  localparam logic [32:0] CAP = 33'(1) << ADDR_W;
  state_t          state;
  logic [15:0]     len;
  logic [23:0]     shf;
  logic [1:0]      bcnt;
  logic [ADDR_W:0] wcnt;
  logic [15:0]     n;
  assign n = {len[15:8], RxData};
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      W_Ins  <= '0;
      WE     <= 1'b0;
      WAddr  <= '0;
      CpuRST <= 1'b1;
      Done   <= 1'b0;
      Err    <= 1'b0;
      len    <= '0;
      shf    <= '0;
      bcnt   <= '0;
      wcnt   <= '0;
    end else if (Start) begin
      state  <= LEN_HI;
      WE     <= 1'b0;
      WAddr  <= '0;
      CpuRST <= 1'b1;
      Done   <= 1'b0;
      Err    <= 1'b0;
      len    <= '0;
      bcnt   <= '0;
      wcnt   <= '0;
    end else begin
      WE <= 1'b0;
      case (state)
        LEN_HI: if (RxValid) begin
          len[15:8] <= RxData;
          state     <= LEN_LO;
        end
        LEN_LO: if (RxValid) begin
          len[7:0] <= RxData;
          if (n == 16'd0) begin
            state  <= DONE;
            Done   <= 1'b1;
            CpuRST <= 1'b0;
          end else if (33'(n) > CAP) begin
            state <= ERR;
            Err   <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          // the last word's WE cycle doubles as the hand-off to DONE; a byte arriving then is dropped
          if (WE && 32'(wcnt) == 32'(len)) begin
            state  <= DONE;
            Done   <= 1'b1;
            CpuRST <= 1'b0;
          end else if (RxValid) begin
            if (bcnt == 2'd3) begin
              W_Ins <= {shf, RxData};
              WAddr <= wcnt[ADDR_W-1:0];
              WE    <= 1'b1;
              wcnt  <= wcnt + 1'b1;
            end else begin
              shf <= {shf[15:0], RxData};
            end
            bcnt <= bcnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ins_loader.sv
// tb_ins_loader: directed and randomized checks of ins_loader against a stream-level reference model.
module tb_ins_loader;
  logic        CLK = 1'b0;
  logic        RST, Start, RxValid;
  logic [7:0]  RxData;
  logic [31:0] W_Ins;
  logic        WE, CpuRST, Done, Err;
  logic [7:0]  WAddr;
  int errors = 0;
  int checks = 0;
  logic [39:0] obs[$];
  always #5 CLK = ~CLK;
  ins_loader #(.ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .RxData(RxData), .RxValid(RxValid),
    .W_Ins(W_Ins), .WE(WE), .WAddr(WAddr), .CpuRST(CpuRST), .Done(Done), .Err(Err)
  );
  always @(negedge CLK) if (WE) obs.push_back({WAddr, W_Ins});
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(logic [7:0] b);
    RxData = b;
    RxValid = 1'b1;
    step();
    RxValid = 1'b0;
    RxData = 8'($urandom);
  endtask
  task automatic start();
    obs.delete();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask
  task automatic outs(string tag, logic we, logic done, logic err, logic cpu);
    check(tag, {28'd0, WE, Done, Err, CpuRST}, {28'd0, we, done, err, cpu});
  endtask
  task automatic run_load(int n, int gmax, int extra, int trunc);
    logic [7:0]  q[$];
    logic [39:0] exp[$];
    int nn, dlen;
    bit done, err;
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    dlen = (n >= 1 && n <= 256) ? 4 * n - trunc : 0;
    for (int i = 0; i < dlen + extra; i++) q.push_back(8'($urandom));
    nn = {q[0], q[1]};
    err = nn > 256;
    done = nn == 0 || (!err && q.size() >= 2 + 4 * nn);
    for (int i = 0; i < nn && !err && 2 + 4 * i + 3 < q.size(); i++)
      exp.push_back({8'(i), q[2+4*i], q[3+4*i], q[4+4*i], q[5+4*i]});
    start();
    foreach (q[i]) begin
      repeat ($urandom_range(gmax)) step();
      send(q[i]);
    end
    repeat (3) step();
    check($sformatf("rnd_n%0d_count", n), obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      check($sformatf("rnd_n%0d_addr%0d", n, i), 32'(obs[i][39:32]), 32'(exp[i][39:32]));
      check($sformatf("rnd_n%0d_ins%0d", n, i), obs[i][31:0], exp[i][31:0]);
    end
    outs($sformatf("rnd_n%0d_status", n), 1'b0, done, err, !done);
  endtask
  initial begin
    int ns[12] = '{0, 1, 2, 3, 5, 7, 256, 257, 1000, 65535, 4, 6};
    RST = 1'b1; Start = 1'b0; RxValid = 1'b0; RxData = 8'd0;
    repeat (2) step();
    RST = 1'b0;
    outs("reset_outs", 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_ins", W_Ins, 32'd0);
    check("reset_addr", 32'(WAddr), 32'd0);
    start();
    send(8'h00); send(8'h02); send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    outs("two_w0_flags", 1'b1, 1'b0, 1'b0, 1'b1);
    check("two_w0_ins", W_Ins, 32'h20080005);
    check("two_w0_addr", 32'(WAddr), 32'd0);
    send(8'hAC);
    outs("two_we_pulse", 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h08); send(8'h00); send(8'h00);
    outs("two_w1_flags", 1'b1, 1'b0, 1'b0, 1'b1);
    check("two_w1_ins", W_Ins, 32'hAC080000);
    check("two_w1_addr", 32'(WAddr), 32'd1);
    step();
    outs("two_done", 1'b0, 1'b1, 1'b0, 1'b0);
    check("two_hold_ins", W_Ins, 32'hAC080000);
    start();
    outs("zero_armed", 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h00); send(8'h00);
    outs("zero_done", 1'b0, 1'b1, 1'b0, 1'b0);
    check("zero_nowe", obs.size(), 0);
    start();
    send(8'h01); send(8'h01);
    outs("len_err", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h00); send(8'h00); send(8'h12); send(8'h34); send(8'h56); step();
    outs("err_sticky", 1'b0, 1'b0, 1'b1, 1'b1);
    check("err_nowe", obs.size(), 0);
    start();
    outs("err_rearm", 1'b0, 1'b0, 1'b0, 1'b1);
    start();
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    start();
    send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("restart_ins", W_Ins, 32'h11223344);
    check("restart_addr", 32'(WAddr), 32'd0);
    step();
    outs("restart_done", 1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_count", obs.size(), 1);
    start();
    send(8'h00); send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    outs("lastwe_pending", 1'b1, 1'b0, 1'b0, 1'b1);
    start();
    outs("lastwe_suppress", 1'b0, 1'b0, 1'b0, 1'b1);
    check("lastwe_addr", 32'(WAddr), 32'd0);
    send(8'h00); send(8'h00);
    outs("lastwe_lenhi", 1'b0, 1'b1, 1'b0, 1'b1 ^ 1'b1);
    Start = 1'b1; RxValid = 1'b1; RxData = 8'hFF;
    step();
    Start = 1'b0; RxValid = 1'b0;
    send(8'h00); send(8'h00);
    outs("start_wins", 1'b0, 1'b1, 1'b0, 1'b0);
    start();
    send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
    RST = 1'b1;
    step();
    RST = 1'b0;
    outs("midword_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("midword_rst_ins", W_Ins, 32'd0);
    check("midword_rst_addr", 32'(WAddr), 32'd0);
    send(8'h44); send(8'h55); send(8'h66); send(8'h77); send(8'h88); step();
    check("midword_rst_nowe", obs.size(), 0);
    outs("midword_rst_idle", 1'b0, 1'b0, 1'b0, 1'b1);
    start();
    send(8'h00); send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    RST = 1'b1; Start = 1'b1;
    step();
    RST = 1'b0; Start = 1'b0;
    outs("we_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("we_rst_ins", W_Ins, 32'd0);
    send(8'h00); send(8'h00); step();
    outs("we_rst_idle", 1'b0, 1'b0, 1'b0, 1'b1);
    foreach (ns[i]) run_load(ns[i], (i % 2) ? 5 : 0, 3, 0);
    for (int i = 0; i < 8; i++) run_load($urandom_range(1, 12), $urandom_range(5), $urandom_range(3), 0);
    run_load(3, 5, 0, 2);
    run_load(9, 2, 0, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ins_loader.md
INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width; capacity is 2**ADDR_W words.
REQ-002 Port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port RST, input, 1: reset, synchronous and active-high.
REQ-004 Port Start, input, 1: arm/re-arm a load; sampled each cycle.
REQ-005 Port RxData, input, 8: incoming program byte.
REQ-006 Port RxValid, input, 1: RxData valid this cycle; always accepted, no backpressure.
REQ-007 Port W_Ins, output, 32: assembled instruction word for the IF instruction-memory write port.
REQ-008 Port WE, output, 1: instruction-memory write strobe, one cycle per word.
REQ-009 Port WAddr, output, ADDR_W: word index of the current W_Ins.
REQ-010 Port CpuRST, output, 1: holds the CPU in reset while loading.
REQ-011 Port Done, output, 1: load completed successfully.
REQ-012 Port Err, output, 1: load aborted because of a length error.

Function
REQ-013 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, DONE and ERR.
REQ-014 Stream format SHALL be a 16-bit big-endian word count N (LEN_HI byte, then LEN_LO byte), followed by 4*N instruction bytes.
REQ-015 Transitions SHALL be: IDLE -Start-> LEN_HI; LEN_HI -byte-> LEN_LO; LEN_LO -byte-> DATA if 0<N<=2**ADDR_W, DONE if N=0, ERR if N>2**ADDR_W; DATA -> DONE after the N-th word is written.
REQ-016 Bytes SHALL advance state only in cycles with RxValid=1; RxData SHALL be ignored otherwise.
REQ-017 Word assembly SHALL be big-endian: first byte to W_Ins[31:24], fourth byte to W_Ins[7:0].
REQ-018 WE SHALL be high for exactly one cycle, the cycle after the 4th byte of a word is accepted, with W_Ins and WAddr valid in that cycle.
REQ-019 W_Ins and WAddr SHALL hold their values until the next word's WE.
REQ-020 WAddr SHALL be 0 for the first word and increment by 1 after each WE; it SHALL never wrap within one load.
REQ-021 Transition to DONE after the last word SHALL occur in the same cycle as its WE; Done and CpuRST=0 SHALL take effect from the next cycle.
REQ-022 CpuRST SHALL be 1 in every state except DONE.
REQ-023 Done SHALL be 1 only in DONE; Err SHALL be 1 only in ERR.
REQ-024 In DONE and ERR, RxValid SHALL be ignored; both states SHALL be left only via Start or RST.
REQ-025 Start in any state SHALL go to LEN_HI, discard any partial word and byte count, clear WAddr to 0 and deassert WE.
REQ-026 Start and RxValid in the same cycle: Start wins and that byte SHALL be discarded.
REQ-027 Start while the last word's WE is pending: WE SHALL be suppressed and the state SHALL go to LEN_HI.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE, W_Ins=0, WE=0, WAddr=0, CpuRST=1, Done=0, Err=0, and clear the byte and word counters.
REQ-029 RST SHALL take precedence over Start and RxValid, including mid-word and during a WE cycle.

Verification
REQ-030 Start, bytes 00 02 | 20 08 00 05 | AC 08 00 00 -> WE twice: W_Ins=0x20080005 at WAddr=0, then 0xAC080000 at WAddr=1; next cycle Done=1, CpuRST=0.
REQ-031 Start, bytes 00 00 -> Done=1 and CpuRST=0 one cycle after the LEN_LO byte; WE never asserted.
REQ-032 ADDR_W=8, Start, bytes 01 01 -> Err=1, CpuRST=1, no WE; further bytes ignored; Start then re-arms (Err=0).
REQ-033 Start, 00 01 AA BB, Start, 00 01 11 22 33 44 -> single WE with W_Ins=0x11223344 at WAddr=0; AA BB discarded.
REQ-034 RST asserted after 3 data bytes of word 1 -> IDLE with all outputs at reset values; with Start low, later bytes produce no WE.
REQ-035 Gaps of 0-5 idle cycles (RxValid=0) between bytes -> same W_Ins/WAddr sequence as back-to-back delivery, one WE per word.
